game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 46 ++++
 rtl/game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Handshake bundle between game_ctrl and the board datapath / win-lose logic.
// move_count is present only when GAME_CTRL_MOVE_COUNT_EN is defined.
interface game_ctrl_if;
    logic                  dir_valid;
    logic [1:0]            dir;
    logic                  new_game;
    logic [3:0][3:0][11:0] board_in;   // [row][col], each cell holds the tile value
    logic                  move_done;
    logic                  board_changed;
    logic                  win_in;
    logic                  lose_in;

    logic                  move_start;
    logic [1:0]            move_dir;
    logic                  clear_board;
    logic                  spawn_we;
    logic [1:0]            spawn_row;
    logic [1:0]            spawn_col;
    logic [11:0]           spawn_val;
    logic                  busy;
    logic                  game_won;
    logic                  game_over;
`ifdef GAME_CTRL_MOVE_COUNT_EN
    logic [15:0]           move_count;
`endif

    modport master (
        output dir_valid, dir, new_game, board_in, move_done, board_changed,
               win_in, lose_in,
`ifdef GAME_CTRL_MOVE_COUNT_EN
        input  move_count,
`endif
        input  move_start, move_dir, clear_board, spawn_we, spawn_row,
               spawn_col, spawn_val, busy, game_won, game_over
    );

    modport slave (
        input  dir_valid, dir, new_game, board_in, move_done, board_changed,
               win_in, lose_in,
`ifdef GAME_CTRL_MOVE_COUNT_EN
        output move_count,
`endif
        output move_start, move_dir, clear_board, spawn_we, spawn_row,
               spawn_col, spawn_val, busy, game_won, game_over
    );
endinterface

// File: rtl/game_ctrl.sv
// Sequencing controller for a 4x4 sliding-tile game: board init, move handshake,
// random tile spawn and win/lose. GAME_CTRL_MOVE_COUNT_EN adds a saturating move counter.
//
// state      | meaning
// INIT_CLR   | pulse clear_board once
// INIT_SPAWN | run the spawn scan twice for the starting tiles
// IDLE       | wait for a move request
// MOVE       | datapath shifting/merging, wait for move_done
// SPAWN      | spawn scan after a board-changing move
// CHECK      | sample win_in / lose_in for one cycle
// WIN        | game won, wait for new_game
// LOSE       | no move left, wait for new_game
module game_ctrl #(
    parameter int MAX_WIN = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    game_ctrl_if.slave bus
);

    if (MAX_WIN < 2 || MAX_WIN > 11) begin : g_bad_max_win
        $error("game_ctrl: MAX_WIN must be 2..11 so the win tile fits in 12 bits");
    end

    typedef enum logic [2:0] {
        INIT_CLR, INIT_SPAWN, IDLE, MOVE, SPAWN, CHECK, WIN, LOSE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_idx;
    logic [3:0]  r_tested;
    logic        r_scan_first;
    logic        r_init_second;
    logic        r_mask_vld;
    logic [3:0]  r_mask_idx;

    logic        r_move_start;
    logic [1:0]  r_move_dir;
    logic        r_clear_board;
    logic        r_spawn_we;
    logic [1:0]  r_spawn_row;
    logic [1:0]  r_spawn_col;
    logic [11:0] r_spawn_val;
    logic        r_busy;
    logic        r_game_won;
    logic        r_game_over;

    logic        w_lfsr_fb;
    logic [3:0]  w_idx;
    logic [11:0] w_cell;
    logic        w_empty;
    logic        w_scan_last;
    logic [11:0] w_new_val;

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_idx       = r_scan_first ? r_lfsr[3:0] : r_idx;
    assign w_cell      = bus.board_in[w_idx[3:2]][w_idx[1:0]];
    // The first init write is not yet visible on board_in, so its cell is masked.
    assign w_empty     = (w_cell == 12'd0) && !(r_mask_vld && (r_mask_idx == w_idx));
    assign w_scan_last = (r_tested == 4'd15);
    assign w_new_val   = (r_lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= INIT_CLR;
            r_idx         <= 4'd0;
            r_tested      <= 4'd0;
            r_scan_first  <= 1'b0;
            r_init_second <= 1'b0;
            r_mask_vld    <= 1'b0;
            r_mask_idx    <= 4'd0;
            r_move_start  <= 1'b0;
            r_move_dir    <= 2'b00;
            r_clear_board <= 1'b0;
            r_spawn_we    <= 1'b0;
            r_spawn_row   <= 2'd0;
            r_spawn_col   <= 2'd0;
            r_spawn_val   <= 12'd0;
            r_busy        <= 1'b0;
            r_game_won    <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_move_start  <= 1'b0;
            r_clear_board <= 1'b0;
            r_spawn_we    <= 1'b0;
            r_spawn_row   <= 2'd0;
            r_spawn_col   <= 2'd0;
            r_spawn_val   <= 12'd0;

            case (r_state)
                INIT_CLR: begin
                    r_busy <= 1'b1;
                    if (r_clear_board) begin
                        r_state       <= INIT_SPAWN;
                        r_scan_first  <= 1'b1;
                        r_tested      <= 4'd0;
                        r_init_second <= 1'b0;
                        r_mask_vld    <= 1'b0;
                    end else begin
                        r_clear_board <= 1'b1;
                    end
                end

                INIT_SPAWN, SPAWN: begin
                    if (w_empty || w_scan_last) begin
                        if (w_empty) begin
                            r_spawn_we  <= 1'b1;
                            r_spawn_row <= w_idx[3:2];
                            r_spawn_col <= w_idx[1:0];
                            r_spawn_val <= w_new_val;
                        end
                        if (r_state == SPAWN) begin
                            r_state <= CHECK;
                        end else if (!r_init_second) begin
                            r_init_second <= 1'b1;
                            r_scan_first  <= 1'b1;
                            r_tested      <= 4'd0;
                            r_mask_vld    <= w_empty;
                            r_mask_idx    <= w_idx;
                        end else begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_mask_vld <= 1'b0;
                        end
                    end else begin
                        r_idx        <= w_idx + 4'd1;
                        r_tested     <= r_tested + 4'd1;
                        r_scan_first <= 1'b0;
                    end
                end

                IDLE: begin
                    if (bus.dir_valid) begin
                        r_move_dir   <= bus.dir;
                        r_move_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= MOVE;
                    end
                end

                MOVE: begin
                    if (bus.move_done) begin
                        if (bus.board_changed) begin
                            r_state      <= SPAWN;
                            r_scan_first <= 1'b1;
                            r_tested     <= 4'd0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                CHECK: begin
                    r_busy <= 1'b0;
                    if (bus.win_in) begin
                        r_state    <= WIN;
                        r_game_won <= 1'b1;
                    end else if (bus.lose_in) begin
                        r_state     <= LOSE;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                WIN, LOSE: begin
                    if (bus.new_game) begin
                        r_state       <= INIT_CLR;
                        r_clear_board <= 1'b1;
                        r_busy        <= 1'b1;
                        r_game_won    <= 1'b0;
                        r_game_over   <= 1'b0;
                    end
                end

                default: r_state <= INIT_CLR;
            endcase
        end
    end

`ifdef GAME_CTRL_MOVE_COUNT_EN
    logic [15:0] r_move_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_move_count <= 16'd0;
        end else if (r_state == INIT_CLR) begin
            r_move_count <= 16'd0;
        end else if (r_state == MOVE && bus.move_done && bus.board_changed
                     && r_move_count != 16'hFFFF) begin
            r_move_count <= r_move_count + 16'd1;
        end
    end

    assign bus.move_count = r_move_count;
`endif

    assign bus.move_start  = r_move_start;
    assign bus.move_dir    = r_move_dir;
    assign bus.clear_board = r_clear_board;
    assign bus.spawn_we    = r_spawn_we;
    assign bus.spawn_row   = r_spawn_row;
    assign bus.spawn_col   = r_spawn_col;
    assign bus.spawn_val   = r_spawn_val;
    assign bus.busy        = r_busy;
    assign bus.game_won    = r_game_won;
    assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: table of move vectors plus hand sequences for
// init spawns, scan wrap, full board, win priority and reset mid-move.
module tb_game_ctrl;

    typedef struct packed {
        logic [1:0] dir;
        logic       changed;
        logic       win;
        logic       lose;
        logic       exp_spawn;
        logic       exp_won;
        logic       exp_over;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;
    int          spawn_cnt = 0;
    int          leak = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    vec_t        vecs [8];

    game_ctrl_if bus ();

    game_ctrl #(.MAX_WIN(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: prev holds the value the controller used at the last edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lstep(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.spawn_we)
                spawn_cnt <= spawn_cnt + 1;
            else if (bus.spawn_row != 2'd0 || bus.spawn_col != 2'd0 || bus.spawn_val != 12'd0)
                leak <= leak + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int k;
        k = 0;
        while (bus.busy && k < maxc) begin
            tick();
            k++;
        end
        chk(nm, 32'(bus.busy), 0);
    endtask

    task automatic set_board(input logic [11:0] fill, input logic hole33);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.board_in[r[1:0]][c[1:0]] = (hole33 && r == 3 && c == 3) ? 12'd0 : fill;
    endtask

    initial begin
        int s0;
        int first_k;
        int exp_val;
        int got_row;
        int got_col;
        int got_val;
        int k;
        logic [15:0] nxt;

        vecs[0] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n             = 1'b0;
        bus.dir_valid     = 1'b0;
        bus.dir           = 2'b00;
        bus.new_game      = 1'b0;
        bus.move_done     = 1'b0;
        bus.board_changed = 1'b0;
        bus.win_in        = 1'b0;
        bus.lose_in       = 1'b0;
        set_board(12'd0, 1'b0);
        #2;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst clear_board", 32'(bus.clear_board), 0);
        chk("rst move_dir", 32'(bus.move_dir), 0);
        chk("rst spawn_we", 32'(bus.spawn_we), 0);

        // Init: clear, then spawns at (1,3)=2 and (3,3)=4 from the seeded LFSR.
        tick();
        rst_n = 1'b1;
        tick();
        chk("init clear_board", 32'(bus.clear_board), 1);
        chk("init busy", 32'(bus.busy), 1);
        tick();
        chk("init clear_board drop", 32'(bus.clear_board), 0);
        chk("init no early spawn", 32'(bus.spawn_we), 0);
        tick();
        chk("init spawn1 we", 32'(bus.spawn_we), 1);
        chk("init spawn1 cell", 32'({bus.spawn_row, bus.spawn_col}), 32'h7);
        chk("init spawn1 val", 32'(bus.spawn_val), 2);
        tick();
        chk("init spawn2 we", 32'(bus.spawn_we), 1);
        chk("init spawn2 cell", 32'({bus.spawn_row, bus.spawn_col}), 32'hF);
        chk("init spawn2 val", 32'(bus.spawn_val), 4);
        chk("init idle busy", 32'(bus.busy), 0);
        tick();
        chk("init spawn count", spawn_cnt, 2);

        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        chk("idle ignores new_game", 32'({bus.clear_board, bus.busy}), 0);

        for (int i = 0; i < 8; i++) begin
            s0 = spawn_cnt;
            bus.dir_valid = 1'b1;
            bus.dir       = vecs[i].dir;
            bus.win_in    = vecs[i].win;
            bus.lose_in   = vecs[i].lose;
            tick();
            bus.dir_valid = 1'b0;
            bus.dir       = ~vecs[i].dir;
            chk($sformatf("v%0d move_start", i), 32'(bus.move_start), 1);
            chk($sformatf("v%0d move_dir", i), 32'(bus.move_dir), 32'(vecs[i].dir));
            bus.move_done     = 1'b1;
            bus.board_changed = vecs[i].changed;
            tick();
            bus.move_done     = 1'b0;
            bus.board_changed = 1'b0;
            chk($sformatf("v%0d move_start pulse", i), 32'(bus.move_start), 0);
            wait_idle($sformatf("v%0d settle", i), 40);
            chk($sformatf("v%0d spawns", i), spawn_cnt - s0, 32'(vecs[i].exp_spawn));
            chk($sformatf("v%0d game_won", i), 32'(bus.game_won), 32'(vecs[i].exp_won));
            chk($sformatf("v%0d game_over", i), 32'(bus.game_over), 32'(vecs[i].exp_over));
            chk($sformatf("v%0d move_dir held", i), 32'(bus.move_dir), 32'(vecs[i].dir));
            bus.win_in  = 1'b0;
            bus.lose_in = 1'b0;
            if (vecs[i].exp_won || vecs[i].exp_over) begin
                bus.new_game = 1'b1;
                tick();
                bus.new_game = 1'b0;
                chk($sformatf("v%0d restart clear", i), 32'(bus.clear_board), 1);
                s0 = spawn_cnt;
                wait_idle($sformatf("v%0d restart", i), 60);
                chk($sformatf("v%0d restart spawns", i), spawn_cnt - s0, 2);
            end
            tick();
        end
`ifdef GAME_CTRL_MOVE_COUNT_EN
        chk("move_count after 3 moves", 32'(bus.move_count), 3);
`endif

        // Scan wrap: only (3,3) empty, start index 0 -> 16 test cycles.
        set_board(12'd2, 1'b1);
        bus.dir_valid = 1'b1;
        bus.dir       = 2'b11;
        tick();
        bus.dir_valid = 1'b0;
        bus.dir_valid = 1'b1;
        bus.dir       = 2'b00;
        tick();
        bus.dir_valid = 1'b0;
        chk("move ignores dir_valid", 32'({bus.move_start, bus.move_dir}), 32'h3);
        k   = 0;
        nxt = lstep(m_lfsr);
        while (nxt[3:0] != 4'd0 && k < 400) begin
            tick();
            nxt = lstep(m_lfsr);
            k++;
        end
        chk("lfsr align", 32'(nxt[3:0] == 4'd0), 1);
        s0 = spawn_cnt;
        bus.move_done     = 1'b1;
        bus.board_changed = 1'b1;
        tick();
        bus.move_done     = 1'b0;
        bus.board_changed = 1'b0;
        first_k = 0;
        exp_val = 0;
        got_row = 0;
        got_col = 0;
        got_val = 0;
        for (int j = 1; j <= 20; j++) begin
            if (bus.spawn_we && first_k == 0) begin
                first_k = j;
                exp_val = (m_prev[7:4] == 4'd0) ? 4 : 2;
                got_row = 32'(bus.spawn_row);
                got_col = 32'(bus.spawn_col);
                got_val = 32'(bus.spawn_val);
            end
            tick();
        end
        chk("wrap latency", first_k, 17);
        chk("wrap row", got_row, 3);
        chk("wrap col", got_col, 3);
        chk("wrap val", got_val, exp_val);
        chk("wrap spawns", spawn_cnt - s0, 1);
        chk("wrap idle", 32'(bus.busy), 0);

        // Full board: no spawn, CHECK with win and lose both set -> WIN.
        set_board(12'd2, 1'b0);
        bus.win_in    = 1'b1;
        bus.lose_in   = 1'b1;
        bus.dir_valid = 1'b1;
        bus.dir       = 2'b01;
        tick();
        bus.dir_valid     = 1'b0;
        bus.move_done     = 1'b1;
        bus.board_changed = 1'b1;
        tick();
        bus.move_done     = 1'b0;
        bus.board_changed = 1'b0;
        s0 = spawn_cnt;
        for (int j = 1; j < 17; j++) tick();
        chk("full check busy", 32'(bus.busy), 1);
        tick();
        chk("full game_won", 32'(bus.game_won), 1);
        chk("full game_over", 32'(bus.game_over), 0);
        chk("full busy", 32'(bus.busy), 0);
        chk("full no spawn", spawn_cnt - s0, 0);
        bus.win_in  = 1'b0;
        bus.lose_in = 1'b0;
        tick();
        chk("win holds", 32'(bus.game_won), 1);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        set_board(12'd0, 1'b0);
        chk("win new_game clear", 32'(bus.clear_board), 1);
        chk("win new_game won drop", 32'(bus.game_won), 0);
        wait_idle("win restart", 60);
`ifdef GAME_CTRL_MOVE_COUNT_EN
        chk("move_count cleared", 32'(bus.move_count), 0);
`endif

        // Reset asserted mid-MOVE while move_done/board_changed are pending.
        bus.dir_valid = 1'b1;
        bus.dir       = 2'b11;
        tick();
        bus.dir_valid = 1'b0;
        tick();
        s0 = spawn_cnt;
        bus.move_done     = 1'b1;
        bus.board_changed = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(bus.busy), 0);
        chk("async rst move_dir", 32'(bus.move_dir), 0);
        chk("async rst outputs", 32'({bus.move_start, bus.clear_board, bus.spawn_we,
                                      bus.game_won, bus.game_over}), 0);
        tick();
        chk("rst no spawn", spawn_cnt - s0, 0);
        bus.move_done     = 1'b0;
        bus.board_changed = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst release clear", 32'(bus.clear_board), 1);
        s0 = spawn_cnt;
        wait_idle("rst reinit", 60);
        chk("rst reinit spawns", spawn_cnt - s0, 2);

        chk("spawn fields zero when idle", leak, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
